// File: rtl/reg_file_master.sv
// Initiator for a register-file port: sequences WrEn/RdEn strobes for single
// valid/ready requests, returns a held response, and runs a clear sweep.
module reg_file_master #(
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   MEM_WIDTH  = 16,
  parameter int                   MEM_DEPTH  = 8,
  parameter logic [MEM_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  // Handshakes: a transfer happens on a rising CLK edge where valid && ready.
  // rsp_valid holds data/err stable until rsp_ready; req_ready stays low
  // from accept until that response handshake completes.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [MEM_WIDTH-1:0]  WrData,
  input  logic [MEM_WIDTH-1:0]  RdData,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD     = 3'd2,
    S_RD_CAP = 3'd3,
    S_RESP   = 3'd4,
    S_CLR    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [MEM_WIDTH-1:0]    r_wdata;
  logic [MEM_WIDTH-1:0]    r_rdata;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    w_accept;
  logic                    w_addr_err;

  assign w_accept   = req_valid && req_ready;
  assign w_addr_err = ({1'b0, req_addr} >= DEPTH_EXT);
  assign dbg_state  = r_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        // Clear wins over a same-cycle request; req_ready is already low then.
        if (clr_start) begin
          w_state_nxt = S_CLR;
        end else if (w_accept) begin
          if (w_addr_err)     w_state_nxt = S_RESP;
          else if (req_write) w_state_nxt = S_WR;
          else                w_state_nxt = S_RD;
        end
      end
      S_WR:     w_state_nxt = S_RESP;
      S_RD:     w_state_nxt = S_RD_CAP;
      S_RD_CAP: w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      S_CLR:    if (r_cnt == LAST_ADDR) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_addr_err;
          end
        end
        // RdData is only meaningful the cycle after RdEn, so capture here only.
        S_RD_CAP: r_rdata <= RdData;
        S_CLR:    r_cnt   <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == S_IDLE) && !clr_start && !RST;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    Address   = '0;
    WrData    = '0;
    unique case (r_state)
      S_WR: begin
        WrEn    = 1'b1;
        Address = r_addr;
        WrData  = r_wdata;
      end
      S_RD: begin
        RdEn    = 1'b1;
        Address = r_addr;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
      end
      S_CLR: begin
        WrEn     = 1'b1;
        Address  = r_cnt;
        WrData   = CLR_VALUE;
        clr_busy = 1'b1;
        clr_done = (r_cnt == LAST_ADDR);
      end
      default: ;
    endcase
  end

endmodule
